// File: rtl/ckp_wheel_generator.sv
// Crankshaft trigger-wheel emulator: N-minus-M tooth pattern at a programmable
// tooth period. Period updates take effect only on tooth-slot boundaries.
module ckp_wheel_generator #(
    parameter int NUM_TEETH     = 36,
    parameter int MISSING_TEETH = 1,
    parameter int PERIOD_WIDTH  = 24,
    parameter int MIN_PERIOD    = 4,
    localparam int TW           = $clog2(NUM_TEETH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    on,
    input  logic                    period_valid,
    input  logic [PERIOD_WIDTH-1:0] tooth_period,
    output logic                    ckp,
    output logic [TW-1:0]           tooth_index,
    output logic                    sync_pulse,
    output logic                    busy,
    output logic [15:0]             rev_count
);

    typedef enum logic [1:0] {IDLE, TOOTH_HIGH, TOOTH_LOW, GAP} state_t;

    localparam logic [TW-1:0]           LAST_IDX  = TW'(NUM_TEETH - 1);
    localparam logic [TW-1:0]           FIRST_GAP = TW'(NUM_TEETH - MISSING_TEETH);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] active_period;
    logic [PERIOD_WIDTH-1:0] pending_period;
    logic                    pending_flag;

    // A strobe landing on a boundary cycle must reach the very next slot, so
    // the boundary looks at the would-be pending value, not the registered one.
    logic [PERIOD_WIDTH-1:0] pend_val;
    logic                    pend_set;
    logic [PERIOD_WIDTH-1:0] cnt_inc;
    logic [PERIOD_WIDTH-1:0] half;
    logic                    slot_end;
    logic [TW-1:0]           next_idx;
    logic                    next_real;

    always_comb begin
        pend_val = pending_period;
        pend_set = pending_flag;
        if (period_valid) begin
            pend_val = (tooth_period < MIN_P) ? MIN_P : tooth_period;
            pend_set = 1'b1;
        end
    end

    assign cnt_inc   = cnt + PERIOD_WIDTH'(1);
    assign half      = active_period >> 1;
    assign slot_end  = (cnt == active_period - PERIOD_WIDTH'(1));
    assign next_idx  = (tooth_index == LAST_IDX) ? '0 : tooth_index + TW'(1);
    assign next_real = (next_idx < FIRST_GAP);
    assign busy      = (state != IDLE);

    // NOTE: all state here is sequential and uses non-blocking assignments, so
    // every branch below reads the pre-edge values; later assignments to the
    // same register in this block override earlier defaults.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            active_period  <= MIN_P;
            pending_period <= MIN_P;
            pending_flag   <= 1'b0;
            ckp            <= 1'b0;
            tooth_index    <= '0;
            sync_pulse     <= 1'b0;
            rev_count      <= '0;
        end else begin
            pending_period <= pend_val;
            pending_flag   <= pend_set;
            sync_pulse     <= 1'b0;
            case (state)
                IDLE: begin
                    ckp         <= 1'b0;
                    tooth_index <= '0;
                    cnt         <= '0;
                    if (on) begin
                        state      <= TOOTH_HIGH;
                        ckp        <= 1'b1;
                        sync_pulse <= 1'b1;
                        if (pend_set) begin
                            active_period <= pend_val;
                            pending_flag  <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (slot_end) begin
                        cnt <= '0;
                        if (pend_set) begin
                            active_period <= pend_val;
                            pending_flag  <= 1'b0;
                        end
                        if (tooth_index == LAST_IDX)
                            rev_count <= rev_count + 16'd1;
                        if (!on) begin
                            state       <= IDLE;
                            ckp         <= 1'b0;
                            tooth_index <= '0;
                        end else begin
                            tooth_index <= next_idx;
                            ckp         <= next_real;
                            state       <= next_real ? TOOTH_HIGH : GAP;
                            sync_pulse  <= (next_idx == '0);
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (state != GAP) begin
                            ckp   <= (cnt_inc < half);
                            state <= (cnt_inc < half) ? TOOTH_HIGH : TOOTH_LOW;
                        end
                    end
                end
            endcase
        end
    end

endmodule
